// File: rtl/e5_pipe_pkg.sv
// Shared types and sizes for the decode-side hazard scoreboard.
package e5_pipe_pkg;

  localparam int REG_IDX_W = 5;
  localparam int NUM_REGS  = 32;

  typedef enum logic [1:0] {
    S_CLEAR = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } sb_state_t;

endpackage

// File: rtl/fp_scoreboard_ctrl_if.sv
// Decode/writeback/drain signal bundle for fp_scoreboard_ctrl, plus debug view of state and busy bits.
// Issue is a request/response pair: decode holds issue_valid, the instruction is accepted on a falling edge where issue_fire is 1.
interface fp_scoreboard_ctrl_if #(
  parameter int CNT_W = 4
);
  import e5_pipe_pkg::*;

  logic                 issue_valid;
  logic                 issue_long;
  logic [REG_IDX_W-1:0] issue_rd;
  logic                 issue_rd_fp;
  logic                 issue_we;
  logic [REG_IDX_W-1:0] rs1;
  logic [REG_IDX_W-1:0] rs2;
  logic [REG_IDX_W-1:0] rs3;
  logic                 rs1_fp;
  logic                 rs2_fp;
  logic                 rs3_fp;
  logic [2:0]           rs_used;
  logic                 done_valid;
  logic [REG_IDX_W-1:0] done_rd;
  logic                 done_fp;
  logic                 drain_req;
  logic                 stall_D;
  logic                 issue_fire;
  logic                 drain_done;
  logic                 sb_empty;
  logic [CNT_W-1:0]     out_cnt;
  sb_state_t            state;
  logic [NUM_REGS-1:0]  busy_x;
  logic [NUM_REGS-1:0]  busy_f;

  modport master (
    output issue_valid, issue_long, issue_rd, issue_rd_fp, issue_we,
           rs1, rs2, rs3, rs1_fp, rs2_fp, rs3_fp, rs_used,
           done_valid, done_rd, done_fp, drain_req,
    input  stall_D, issue_fire, drain_done, sb_empty, out_cnt,
           state, busy_x, busy_f
  );

  modport slave (
    input  issue_valid, issue_long, issue_rd, issue_rd_fp, issue_we,
           rs1, rs2, rs3, rs1_fp, rs2_fp, rs3_fp, rs_used,
           done_valid, done_rd, done_fp, drain_req,
    output stall_D, issue_fire, drain_done, sb_empty, out_cnt,
           state, busy_x, busy_f
  );

endinterface

// File: rtl/sb_regfile_bits.sv
// Busy-bit vector for one register file: set on long issue, clear on completion, 3 source + rd lookups.
// SB_BYPASS_EN: a same-cycle completion is masked out of the lookups.
module sb_regfile_bits
  import e5_pipe_pkg::*;
#(
  parameter bit HARD_ZERO = 1'b0
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           set_en,
  input  logic [REG_IDX_W-1:0]           set_idx,
  input  logic                           clr_en,
  input  logic [REG_IDX_W-1:0]           clr_idx,
  input  logic [2:0][REG_IDX_W-1:0]      rs_idx,
  input  logic [REG_IDX_W-1:0]           rd_idx,
  output logic [2:0]                     rs_hit,
  output logic                           rd_hit,
  output logic [NUM_REGS-1:0]            bits
);

  logic [NUM_REGS-1:0] bits_q;
  logic [NUM_REGS-1:0] set_vec;
  logic [NUM_REGS-1:0] clr_vec;
  logic [NUM_REGS-1:0] look_vec;

  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (set_en) set_vec[set_idx] = 1'b1;
    if (clr_en) clr_vec[clr_idx] = 1'b1;
    // x0 is hardwired, so it can never become a hazard
    if (HARD_ZERO) set_vec[0] = 1'b0;
  end

  always_comb begin
`ifdef SB_BYPASS_EN
    look_vec = bits_q & ~clr_vec;
`else
    look_vec = bits_q;
`endif
    for (int i = 0; i < 3; i++) rs_hit[i] = look_vec[rs_idx[i]];
    rd_hit = look_vec[rd_idx];
  end

  // Set wins over clear so a bypassed re-issue to the completing register stays tracked
  always_ff @(negedge clk or negedge reset) begin
    if (!reset) bits_q <= '0;
    else        bits_q <= (bits_q & ~clr_vec) | set_vec;
  end

  assign bits = bits_q;

`ifndef SB_BYPASS_EN
  set_clr_collision: assert property (@(negedge clk) disable iff (!reset)
    !(|(set_vec & clr_vec)));
`endif

endmodule

// File: rtl/fp_scoreboard_ctrl.sv
// Decode hazard scoreboard: RAW/WAW/capacity stall for out-of-band long ops, post-reset clear cycle and drain sequencing.
// SB_BYPASS_EN: same-cycle completions release hazards and capacity combinationally.
module fp_scoreboard_ctrl
  import e5_pipe_pkg::*;
#(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 4
) (
  input  logic                clk,
  input  logic                reset,
  fp_scoreboard_ctrl_if.slave sb
);

  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_OUT);

  sb_state_t                  state_q;
  logic                       drain_done_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [2:0][REG_IDX_W-1:0]  rs_idx;
  logic [2:0]                 rs_fp;
  logic [2:0]                 x_hit;
  logic [2:0]                 f_hit;
  logic [2:0]                 src_hit;
  logic                       x_rd_hit;
  logic                       f_rd_hit;
  logic                       raw;
  logic                       waw;
  logic                       cap_full;
  logic                       cap;
  logic                       stall;
  logic                       fire;
  logic                       set_x;
  logic                       set_f;
  logic                       clr_x;
  logic                       clr_f;
  logic                       inc;
  logic                       dec;

  assign rs_idx = {sb.rs3, sb.rs2, sb.rs1};
  assign rs_fp  = {sb.rs3_fp, sb.rs2_fp, sb.rs1_fp};

  assign set_x = fire & sb.issue_long & sb.issue_we & ~sb.issue_rd_fp;
  assign set_f = fire & sb.issue_long & sb.issue_we &  sb.issue_rd_fp;
  assign clr_x = sb.done_valid & ~sb.done_fp;
  assign clr_f = sb.done_valid &  sb.done_fp;

  sb_regfile_bits #(.HARD_ZERO(1'b1)) u_bits_x (
    .clk     (clk),
    .reset   (reset),
    .set_en  (set_x),
    .set_idx (sb.issue_rd),
    .clr_en  (clr_x),
    .clr_idx (sb.done_rd),
    .rs_idx  (rs_idx),
    .rd_idx  (sb.issue_rd),
    .rs_hit  (x_hit),
    .rd_hit  (x_rd_hit),
    .bits    (sb.busy_x)
  );

  sb_regfile_bits #(.HARD_ZERO(1'b0)) u_bits_f (
    .clk     (clk),
    .reset   (reset),
    .set_en  (set_f),
    .set_idx (sb.issue_rd),
    .clr_en  (clr_f),
    .clr_idx (sb.done_rd),
    .rs_idx  (rs_idx),
    .rd_idx  (sb.issue_rd),
    .rs_hit  (f_hit),
    .rd_hit  (f_rd_hit),
    .bits    (sb.busy_f)
  );

  always_comb begin
    src_hit  = (rs_fp & f_hit) | (~rs_fp & x_hit);
    raw      = |(src_hit & sb.rs_used);
    waw      = sb.issue_we & (sb.issue_rd_fp ? f_rd_hit : x_rd_hit);
    cap_full = (cnt_q == MAX_CNT);
`ifdef SB_BYPASS_EN
    if (sb.done_valid) cap_full = 1'b0;
`endif
    cap = sb.issue_long & cap_full;
    unique case (state_q)
      S_RUN:   stall = sb.issue_valid & (raw | waw | cap);
      default: stall = 1'b1;
    endcase
    fire = sb.issue_valid & ~stall;
  end

  // A completion with nothing outstanding is dropped; the counter never wraps below zero
  assign inc = fire & sb.issue_long;
  assign dec = sb.done_valid & (cnt_q != '0);

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) cnt_q <= '0;
    else        cnt_q <= cnt_q + CNT_W'(inc) - CNT_W'(dec);
  end

  always_ff @(negedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= S_CLEAR;
      drain_done_q <= 1'b0;
    end else begin
      drain_done_q <= 1'b0;
      unique case (state_q)
        S_CLEAR: state_q <= S_RUN;
        S_RUN:   if (sb.drain_req) state_q <= S_DRAIN;
        S_DRAIN: begin
          if (cnt_q == '0) begin
            state_q      <= S_RUN;
            drain_done_q <= 1'b1;
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign sb.stall_D    = stall;
  assign sb.issue_fire = fire;
  assign sb.drain_done = drain_done_q;
  assign sb.sb_empty   = (cnt_q == '0);
  assign sb.out_cnt    = cnt_q;
  assign sb.state      = state_q;

  done_underflow: assert property (@(negedge clk) disable iff (!reset)
    !(sb.done_valid && cnt_q == '0));

endmodule
